// File: rtl/alu_multicycle.sv
// Execution-stage ALU: ADD/SUB/AND complete one cycle after acceptance, signed MUL
// holds the unit for MUL_LATENCY cycles. Valid/ready handshake on the request side.
module alu_multicycle #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_first,
  input  logic [WIDTH-1:0] input_second,
  input  logic [1:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             valid_out
);

  localparam int unsigned CW  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_AND = 2'b11} op_t;
  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic                   r_pend;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  op_t                    r_op;

  logic                   w_accept;
  logic                   w_mul_accept;
  logic                   w_done;
  logic [WIDTH-1:0]       w_sum;
  logic [WIDTH-1:0]       w_diff;
  logic signed [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]       w_res;
  logic                   w_ovf;

  // With a one-cycle multiply there is nothing to wait for, so MUL takes the
  // single-cycle path and the FSM never leaves IDLE.
  always_comb begin
    in_ready     = (r_state == IDLE);
    w_accept     = in_valid && in_ready;
    w_mul_accept = w_accept && (op_t'(alu_op) == OP_MUL) && (MUL_LATENCY > 1);
    w_state_nxt  = r_state;
    case (r_state)
      IDLE:     if (w_mul_accept) w_state_nxt = MUL_BUSY;
      MUL_BUSY: if (r_cnt == '0) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
    w_done = r_pend || ((r_state == MUL_BUSY) && (r_cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_sum  = r_a + r_b;
    w_diff = r_a - r_b;
    w_prod = $signed({{WIDTH{r_a[MSB]}}, r_a}) * $signed({{WIDTH{r_b[MSB]}}, r_b});
    w_res  = '0;
    w_ovf  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      OP_MUL: begin
        w_res = w_prod[WIDTH-1:0];
        w_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[MSB]}});
      end
      default: begin
        w_res = r_a & r_b;
        w_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a  <= input_first;
        r_b  <= input_second;
        r_op <= op_t'(alu_op);
      end
      r_pend <= w_accept && !w_mul_accept;
      if (w_mul_accept)
        r_cnt <= CW'(MUL_LATENCY - 1);
      else if ((r_state == MUL_BUSY) && (r_cnt != '0))
        r_cnt <= r_cnt - 1'b1;
      valid_out <= w_done;
      if (w_done) begin
        result   <= w_res;
        zero     <= (w_res == '0);
        overflow <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, multi-cycle corner sequences and a
// randomized run checked against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 32;
  localparam int L = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;

  logic          in_ready, valid_out, zero, overflow;
  logic [W-1:0]  result;
  logic          in_ready1, valid_out1, zero1, overflow1;
  logic [W-1:0]  result1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  alu_multicycle #(.WIDTH(W), .MUL_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_first(a), .input_second(b), .alu_op(op),
    .result(result), .zero(zero), .overflow(overflow), .valid_out(valid_out)
  );

  alu_multicycle #(.WIDTH(W), .MUL_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .input_first(a), .input_second(b), .alu_op(op),
    .result(result1), .zero(zero1), .overflow(overflow1), .valid_out(valid_out1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         o;
  } vec_t;

  typedef struct {
    int           done;
    logic [W-1:0] r;
    logic         z;
    logic         o;
  } pend_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: exact signed arithmetic in 64 bits, overflow = true result out of range.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic z, output logic ov);
    longint sx, sy, full;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0:    full = sx + sy;
      2'd1:    full = sx - sy;
      2'd2:    full = sx * sy;
      default: full = longint'(x & y);
    endcase
    r  = full[W-1:0];
    z  = (r == 0);
    ov = (o != 2'd3) && ((full > 64'sh000000007FFFFFFF) || (full < -64'sh0000000080000000));
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h7FFFFFFF;
      2:       return 32'h80000000;
      3:       return '1;
      4:       return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("wait_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ez, input logic eo, input string nm);
    int n = 0;
    wait_ready();
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    while (n < 12) begin
      tick();
      n++;
      if (valid_out) break;
    end
    chk($sformatf("%s_lat", nm), 64'(n), (o == 2'd2) ? 64'(L) : 64'd1);
    chk($sformatf("%s_res", nm), 64'(result), 64'(er));
    chk($sformatf("%s_zero", nm), 64'(zero), 64'(ez));
    chk($sformatf("%s_ovf", nm), 64'(overflow), 64'(eo));
    tick();
    chk($sformatf("%s_pulse", nm), 64'(valid_out), 64'd0);
    chk($sformatf("%s_hold", nm), 64'(result), 64'(er));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t     vecs[9];
    pend_t    q[$];
    pend_t    p;
    logic [W-1:0] held_r, mr;
    logic     held_z, held_o, mz, mo, m_ready, exp_v;
    int       ready_at, e, seen;

    vecs[0] = '{2'd0, 32'h0000000E, 32'h00000009, 32'h00000017, 1'b0, 1'b0};
    vecs[1] = '{2'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{2'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{2'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{2'd2, 32'h0000000E, 32'h00000009, 32'h0000007E, 1'b0, 1'b0};
    vecs[5] = '{2'd2, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0, 1'b0};
    vecs[6] = '{2'd2, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{2'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
    vecs[8] = '{2'd3, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].o, $sformatf("vec%0d", i));

    // Back-to-back SUBs: two consecutive valid_out pulses
    wait_ready();
    op = 2'd1; a = 32'd5; b = 32'd5; in_valid = 1'b1;
    tick();
    a = 32'h80000000; b = 32'h00000001;
    tick();
    in_valid = 1'b0;
    chk("b2b_v1", 64'(valid_out), 64'd1);
    chk("b2b_r1", 64'(result), 64'd0);
    chk("b2b_z1", 64'(zero), 64'd1);
    tick();
    chk("b2b_v2", 64'(valid_out), 64'd1);
    chk("b2b_r2", 64'(result), 64'h7FFFFFFF);
    chk("b2b_o2", 64'(overflow), 64'd1);
    tick();
    chk("b2b_v3", 64'(valid_out), 64'd0);

    // MUL timing, ignored requests while busy and in the completion cycle
    wait_ready();
    op = 2'd2; a = 32'hE; b = 32'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    chk("mt_rdy0", 64'(in_ready), 64'd0);
    chk("mt_v0", 64'(valid_out), 64'd0);
    tick();
    chk("mt_rdy1", 64'(in_ready), 64'd0);
    chk("mt_v1", 64'(valid_out), 64'd0);
    chk("l1_valid", 64'(valid_out1), 64'd1);
    chk("l1_res", 64'(result1), 64'h7E);
    chk("l1_ready", 64'(in_ready1), 64'd1);
    op = 2'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    tick();
    chk("mt_rdy2", 64'(in_ready), 64'd0);
    chk("mt_v2", 64'(valid_out), 64'd0);
    tick();
    chk("mt_rdy3", 64'(in_ready), 64'd0);
    chk("mt_v3", 64'(valid_out), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("mt_v4", 64'(valid_out), 64'd1);
    chk("mt_res", 64'(result), 64'h7E);
    chk("mt_ovf", 64'(overflow), 64'd0);
    chk("mt_rdy4", 64'(in_ready), 64'd1);
    tick();
    chk("mt_no_extra", 64'(valid_out), 64'd0);
    chk("mt_hold", 64'(result), 64'h7E);

    // Reset in the middle of a MUL aborts it
    wait_ready();
    op = 2'd2; a = 32'd3; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_result", 64'(result), 64'd0);
    chk("ab_zero", 64'(zero), 64'd0);
    chk("ab_ovf", 64'(overflow), 64'd0);
    chk("ab_valid", 64'(valid_out), 64'd0);
    chk("ab_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_out) seen++;
    end
    chk("ab_no_valid", 64'(seen), 64'd0);
    run_op(2'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, "ab_add");

    // Randomized traffic against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    held_r = '0; held_z = 1'b0; held_o = 1'b0;
    ready_at = cyc;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 2'($urandom);
      a = rand_opnd();
      b = rand_opnd();
      m_ready = (cyc >= ready_at);
      chk("rnd_ready", 64'(in_ready), 64'(m_ready));
      chk("rnd_l1_ready", 64'(in_ready1), 64'd1);
      if (in_valid && m_ready) begin
        model(op, a, b, mr, mz, mo);
        e = cyc + 1;
        p = '{(op == 2'd2) ? e + L : e + 1, mr, mz, mo};
        q.push_back(p);
        if (op == 2'd2) ready_at = e + L;
      end
      tick();
      exp_v = (q.size() > 0) && (q[0].done == cyc);
      chk("rnd_valid", 64'(valid_out), 64'(exp_v));
      if (exp_v) begin
        held_r = q[0].r; held_z = q[0].z; held_o = q[0].o;
        void'(q.pop_front());
      end
      chk("rnd_result", 64'(result), 64'(held_r));
      chk("rnd_zero", 64'(zero), 64'(held_z));
      chk("rnd_ovf", 64'(overflow), 64'(held_o));
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor of the execution-stage ALU.
- Supports ADD, SUB, signed MUL and AND with a valid/ready handshake, a signed-overflow flag and a configurable multiply latency.
- Single-cycle ops complete in one cycle. MUL occupies the unit for MUL_LATENCY cycles, during which the decode/issue stage stalls on in_ready.
- Sits between the register-read stage and writeback in the execution stage.

Parameters:
- WIDTH, 32: operand and result width in bits (>=4).
- MUL_LATENCY, 4: cycles from MUL acceptance to valid_out (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request this cycle
- input_first  input  WIDTH  operand A (two's complement)
- input_second  input  WIDTH  operand B (two's complement)
- alu_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 AND
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- overflow  output  1  signed overflow of the completed op
- valid_out  output  1  one-cycle pulse: result/zero/overflow updated this cycle

Behaviour:
- Reset (rst high at a clock edge) drives:
  - result=0, zero=0, overflow=0, valid_out=0;
  - in_ready=1, FSM to IDLE, multiply counter=0.
- Reset has priority over every other event. Reset mid-MUL aborts the operation; no valid_out is produced for it.
- Accept: a request is accepted when in_valid && in_ready at a rising edge. Operands and alu_op are captured at that edge; later input changes do not affect the op.
- FSM states: IDLE, MUL_BUSY.
  - IDLE, accept ADD/SUB/AND: stay IDLE. On the next edge, result/zero/overflow are registered and valid_out=1 for exactly one cycle. Latency is 1 cycle.
  - IDLE, accept MUL: go to MUL_BUSY, in_ready=0, counter loads MUL_LATENCY-1.
  - MUL_BUSY: counter decrements each edge. When it reaches 0, result is registered, valid_out pulses, and the FSM returns to IDLE with in_ready=1. The MUL result appears MUL_LATENCY cycles after acceptance.
  - MUL_LATENCY=1 behaves like a single-cycle op; in_ready never drops.
- Back-to-back single-cycle ops: accepted on consecutive cycles, giving a valid_out every cycle.
- An op issued in the same cycle the MUL completes is accepted only if in_ready=1 in that cycle. in_ready is combinational from state, so it is 0 in the completion cycle and 1 on the next cycle.
- in_valid while in_ready=0 is ignored: not queued, no error.
- Arithmetic (all results truncated to WIDTH bits):
  - ADD: A+B. overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: A-B. overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - MUL: signed A*B, low WIDTH bits. overflow=1 iff the full 2*WIDTH-bit signed product differs from sign-extension of the low WIDTH bits.
  - AND: bitwise A&B. overflow=0.
- zero is computed from the registered result of the same op.
- result, zero and overflow hold their values between completions. Only valid_out returns to 0.

Test Plan (WIDTH=32, MUL_LATENCY=4):
1. Reset then ADD A=0x0000000E, B=0x00000009 accepted at edge N -> at edge N+1: result=0x00000017, zero=0, overflow=0, valid_out=1 for one cycle. ADD A=0x7FFFFFFF, B=0x00000001 -> result=0x80000000, overflow=1.
2. SUB A=5, B=5 -> result=0, zero=1, overflow=0. SUB A=0x80000000, B=0x00000001 -> result=0x7FFFFFFF, overflow=1. Issue both back-to-back -> two consecutive valid_out pulses.
3. MUL A=0xE, B=0x9 accepted at edge N:
   - in_ready=0 for cycles N+1..N+3;
   - valid_out only at edge N+4, with result=0x0000007E, overflow=0;
   - an ADD presented with in_valid=1 at N+2 is ignored (no extra valid_out).
4. MUL A=0xFFFFFFFD (-3), B=5 -> result=0xFFFFFFF1, overflow=0. MUL A=0x00010000, B=0x00010000 -> result=0, zero=1, overflow=1.
5. AND A=0xF0F0F0F0, B=0x0FF00FF0 -> result=0x00F000F0, overflow=0. AND A=0xFFFF0000, B=0x0000FFFF -> zero=1.
6. Accept MUL, assert rst at edge N+2 -> no valid_out ever for that op. Outputs are all 0 and in_ready=1 from the cycle after reset. A following ADD 1+1 -> result=2 after 1 cycle.
